// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        START,
        WAIT
    } state_t;

    localparam int WORD_SIZE_DEF = 8;
    localparam int FRAME_WAIT    = WORD_SIZE_DEF + 2;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Request selector for the UART transmit arbiter: round-robin by default,
// fixed priority (lowest index wins) when UART_TX_ARB_FIXED_PRIO_EN is defined.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               Clock,
    input  logic               reset_,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] advance,
    output logic [NUM_REQ-1:0] winner
);

`ifdef UART_TX_ARB_FIXED_PRIO_EN

    logic unused_inputs;
    assign unused_inputs = ^{Clock, reset_, advance};

    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (winner == '0)) winner[i] = 1'b1;
        end
    end

`else

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     ptr;
    logic [2*NUM_REQ-1:0] rot_pair;
    logic [2*NUM_REQ-1:0] win_pair;
    logic [NUM_REQ-1:0]   rot_req;
    logic [NUM_REQ-1:0]   rot_win;

    // ptr is where the next search starts: one past the requester just acked.
    always_ff @(posedge Clock or negedge reset_) begin
        if (!reset_) begin
            ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (advance[i]) ptr <= PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_pair = {req, req} >> ptr;
        rot_req  = rot_pair[NUM_REQ-1:0];
        rot_win  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rot_req[i] && (rot_win == '0)) rot_win[i] = 1'b1;
        end
        win_pair = {rot_win, rot_win} << ptr;
        winner   = win_pair[2*NUM_REQ-1:NUM_REQ];
    end

`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Multi-requester front end for a UART transmitter; sequences the load/ready/start
// strobes per frame. Define UART_TX_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_REQ   = 4
) (
    input  logic                         Clock,
    input  logic                         reset_,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         busy,
    output logic [WORD_SIZE-1:0]         Data_Bus,
    output logic                         Load_XMT_datareg,
    output logic                         Byte_ready,
    output logic                         T_byte
);

    localparam int CNT_W = $clog2(WORD_SIZE + 3);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NUM_REQ-1:0] winner;
    logic [NUM_REQ-1:0] advance;
    logic               last_wait;

    assign last_wait = (state == WAIT) && (wait_cnt == '0);
    assign advance   = last_wait ? gnt : '0;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .Clock   (Clock),
        .reset_  (reset_),
        .req     (req),
        .advance (advance),
        .winner  (winner)
    );

    always_ff @(posedge Clock or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req) next_state = LOAD;
            LOAD:    next_state = READY;
            READY:   next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (wait_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // WAIT spans WORD_SIZE+2 cycles: counter loads WORD_SIZE+1 and exits at zero.
    // The ack pulse and gnt clear share the edge that leaves WAIT.
    always_ff @(posedge Clock or negedge reset_) begin
        if (!reset_) begin
            gnt      <= '0;
            ack      <= '0;
            wait_cnt <= '0;
        end else begin
            ack <= advance;
            if (state == START)
                wait_cnt <= CNT_W'(WORD_SIZE + 1);
            else if ((state == WAIT) && (wait_cnt != '0))
                wait_cnt <= wait_cnt - 1'b1;
            if ((state == IDLE) && (|req))
                gnt <= winner;
            else if (last_wait)
                gnt <= '0;
        end
    end

    always_comb begin
        busy             = (state != IDLE);
        Load_XMT_datareg = (state == LOAD);
        Byte_ready       = (state == READY);
        T_byte           = (state == START);
        Data_Bus         = '0;
        if (state == LOAD) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) Data_Bus = Data_Bus | req_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-timeline model checked every cycle plus
// directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int W          = 8;
    localparam int N          = 4;
    localparam int LAST_PHASE = 3 + W + 2 - 1;

    logic           Clock;
    logic           reset_;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           busy;
    logic [W-1:0]   Data_Bus;
    logic           Load_XMT_datareg;
    logic           Byte_ready;
    logic           T_byte;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int           m_phase;
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] m_ack;

    int       grant_q[$];
    int       ack_q[$];
    int       load_cyc_q[$];
    int       load_cyc;
    int       ack_cyc;
    logic [W-1:0] load_data;

    uart_tx_arbiter #(.WORD_SIZE(W), .NUM_REQ(N)) dut (
        .Clock            (Clock),
        .reset_           (reset_),
        .req              (req),
        .req_data         (req_data),
        .gnt              (gnt),
        .ack              (ack),
        .busy             (busy),
        .Data_Bus         (Data_Bus),
        .Load_XMT_datareg (Load_XMT_datareg),
        .Byte_ready       (Byte_ready),
        .T_byte           (T_byte)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int pickWinner(logic [N-1:0] r, int start);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic int oneHotIdx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic modelReset();
        m_phase = -1;
        m_owner = 0;
        m_ptr   = 0;
        m_ack   = '0;
    endtask

    // Phase -1 is idle; phases 0..LAST_PHASE are load, ready, start, then the wait.
    task automatic modelStep();
        m_ack = '0;
        if (m_phase < 0) begin
            if (req != '0) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
                m_owner = pickWinner(req, 0);
`else
                m_owner = pickWinner(req, m_ptr);
`endif
                m_phase = 0;
            end
        end else if (m_phase == LAST_PHASE) begin
            m_ack[m_owner] = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_phase = -1;
        end else begin
            m_phase++;
        end
    endtask

    task automatic compareCycle();
        logic [N-1:0] exp_gnt;
        logic [W-1:0] exp_data;
        exp_gnt  = '0;
        exp_data = '0;
        if (m_phase >= 0) exp_gnt[m_owner] = 1'b1;
        if (m_phase == 0) exp_data = req_data[m_owner*W +: W];
        checkOutput("gnt", gnt, exp_gnt);
        checkOutput("ack", ack, m_ack);
        checkOutput("busy", busy, m_phase >= 0);
        checkOutput("Load_XMT_datareg", Load_XMT_datareg, m_phase == 0);
        checkOutput("Byte_ready", Byte_ready, m_phase == 1);
        checkOutput("T_byte", T_byte, m_phase == 2);
        checkOutput("Data_Bus", Data_Bus, exp_data);
        checkOutput("strobe_exclusive", $countones({Load_XMT_datareg, Byte_ready, T_byte}) <= 1, 1);
        if (Load_XMT_datareg) begin
            grant_q.push_back(oneHotIdx(gnt));
            load_cyc_q.push_back(cyc);
            load_cyc  = cyc;
            load_data = Data_Bus;
        end
        if (ack != '0) begin
            ack_q.push_back(oneHotIdx(ack));
            ack_cyc = cyc;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge Clock);
            cyc++;
            if (!reset_) modelReset();
            else         modelStep();
            @(negedge Clock);
            if (!reset_) modelReset();
            compareCycle();
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d);
        req      = r;
        req_data = d;
    endtask

    task automatic doReset();
        reset_ = 1'b0;
        req    = '0;
        tick();
        tick();
        reset_ = 1'b1;
        tick();
    endtask

    task automatic waitAck(input int i, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (ack[i]) begin
                req[i] = 1'b0;
                seen   = 1'b1;
            end
        end
        if (!seen) checkOutput($sformatf("ack%0d_timeout", i), 0, 1);
    endtask

    task automatic waitIdle(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (!busy && (ack == '0)) seen = 1'b1;
        end
        if (!seen) checkOutput("idle_timeout", 0, 1);
    endtask

    int set_cyc;
    int acks_before;
    int exp_order[5];
    logic [N-1:0] cont_req;

    initial begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        exp_order = '{1, 1, 1, 1, 1};
        cont_req  = 4'b0110;
`else
        exp_order = '{0, 1, 2, 3, 0};
        cont_req  = 4'b1111;
`endif
        reset_ = 1'b0;
        applyStimulus('0, '0);
        repeat (3) tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_strobes", {Load_XMT_datareg, Byte_ready, T_byte, Data_Bus}, 0);
        reset_ = 1'b1;
        tick();

        $display("[TB] single request");
        applyStimulus(4'b0001, 32'h1122_33A5);
        set_cyc = cyc;
        waitAck(0, 30);
        checkOutput("t1_load_latency", load_cyc - set_cyc, 1);
        checkOutput("t1_data", load_data, 8'hA5);
        checkOutput("t1_ack_latency", ack_cyc - set_cyc, 14);
        checkOutput("t1_grant_count", grant_q.size(), 1);
        if (grant_q.size() > 0) checkOutput("t1_grant_idx", grant_q[0], 0);
        waitIdle(10);

        $display("[TB] contention");
        doReset();
        grant_q.delete();
        ack_q.delete();
        load_cyc_q.delete();
        applyStimulus(cont_req, 32'hD4C3_B2A1);
        for (int k = 0; k < 100 && grant_q.size() < 5; k++) tick();
        req = '0;
        waitIdle(40);
        checkOutput("t2_grant_count", grant_q.size(), 5);
        checkOutput("t2_ack_count", ack_q.size(), 5);
        for (int k = 0; k < 5 && k < grant_q.size(); k++)
            checkOutput($sformatf("t2_order%0d", k), grant_q[k], exp_order[k]);
        for (int k = 1; k < 5 && k < load_cyc_q.size(); k++)
            checkOutput($sformatf("t2_spacing%0d", k), load_cyc_q[k] - load_cyc_q[k-1], 14);

        $display("[TB] drop before grant");
        grant_q.delete();
        ack_q.delete();
        applyStimulus(4'b0001, 32'h0077_0033);
        repeat (6) tick();
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        waitAck(0, 30);
        repeat (20) tick();
        checkOutput("t3_grant_count", grant_q.size(), 1);
        checkOutput("t3_ack_count", ack_q.size(), 1);
        checkOutput("t3_grant2", grant_q.size() > 0 ? grant_q[0] : -1, 0);

        $display("[TB] reset mid-frame");
        applyStimulus(4'b0001, 32'h0000_00C3);
        set_cyc = cyc;
        repeat (8) tick();
        checkOutput("t4_busy_before", busy, 1);
        acks_before = ack_q.size();
        reset_ = 1'b0;
        req    = '0;
        #1;
        checkOutput("t4_outputs_zero",
                    {gnt, ack, busy, Load_XMT_datareg, Byte_ready, T_byte, Data_Bus}, 0);
        tick();
        tick();
        reset_ = 1'b1;
        repeat (20) tick();
        checkOutput("t4_no_ack", ack_q.size(), acks_before);
        applyStimulus(4'b0010, 32'h0000_5A00);
        set_cyc = cyc;
        waitAck(1, 30);
        checkOutput("t4_ack_latency", ack_cyc - set_cyc, 14);
        checkOutput("t4_data", load_data, 8'h5A);
        waitIdle(10);

        $display("[TB] random requests");
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(N'($urandom_range(0, 15)), $urandom);
            tick();
        end
        req = '0;
        waitIdle(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 8, data word width; NUM_REQ, default 4, number of requesters.
REQ-002 Clock  input  1  bit clock shared with the transmitter.
REQ-003 reset_  input  1  asynchronous, active-low reset.
REQ-004 req  input  NUM_REQ  per-requester transmit request; a level, held until its ack.
REQ-005 req_data  input  NUM_REQ*WORD_SIZE  per-requester word; slice i = bits [i*WORD_SIZE +: WORD_SIZE].
REQ-006 gnt  output  NUM_REQ  one-hot; owner of the current transfer.
REQ-007 ack  output  NUM_REQ  one-cycle pulse to the owner when its frame is complete.
REQ-008 busy  output  1  high whenever the FSM is not IDLE.
REQ-009 Data_Bus  output  WORD_SIZE  word to the transmitter.
REQ-010 Load_XMT_datareg  output  1  transmitter data-register load strobe.
REQ-011 Byte_ready  output  1  transmitter shift-register load strobe.
REQ-012 T_byte  output  1  transmitter start strobe.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, READY, START and WAIT, with transitions IDLE->LOAD->READY->START->WAIT->IDLE.
REQ-014 IDLE SHALL move to LOAD in the cycle after any req bit is high, registering the winner into gnt at that edge.
REQ-015 IDLE SHALL stay in IDLE with gnt=0 when req=0.
REQ-016 LOAD SHALL hold Load_XMT_datareg=1 for exactly one cycle, with Data_Bus = req_data slice of the granted requester.
REQ-017 READY SHALL hold Byte_ready=1 for exactly one cycle.
REQ-018 START SHALL hold T_byte=1 for exactly one cycle.
REQ-019 WAIT SHALL last exactly WORD_SIZE+2 cycles (9 shifts plus 1 clear for the default width), counted by a $clog2(WORD_SIZE+3)-bit down-counter loaded on entry.
REQ-020 On the last WAIT cycle, the controller SHALL pulse ack of the owner and return to IDLE; gnt SHALL clear on the same edge.
REQ-021 Frame latency from req sampled in IDLE to ack SHALL be 4+WORD_SIZE+2 cycles (14 for the default width).
REQ-022 Only one strobe among Load_XMT_datareg, Byte_ready and T_byte SHALL be high in any cycle.
REQ-023 Data_Bus SHALL be 0 outside LOAD.
REQ-024 Default arbitration SHALL be round-robin: the search starts at (last winner + 1) mod NUM_REQ, and the pointer updates only when an ack is issued.
REQ-025 A req bit that falls before it is granted SHALL be ignored.
REQ-026 A requester's req falling after grant SHALL NOT abort the frame; ack is still issued.
REQ-027 A req that rises in the ack cycle SHALL be eligible in the following IDLE cycle, giving one idle cycle between frames.
REQ-028 An owner still holding req after its ack SHALL compete normally; under round-robin, other requesters win first.

Reset
REQ-029 While reset_=0, the FSM SHALL be in IDLE and gnt, ack, busy, Data_Bus, Load_XMT_datareg, Byte_ready, T_byte, the WAIT counter and the round-robin pointer SHALL all be 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without issuing an ack; the transmitter shares reset_ and so resets coherently.

Configuration
REQ-031 When macro UART_TX_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority (lowest index wins) and the round-robin pointer SHALL be omitted.
REQ-032 When UART_TX_ARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-024.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state typedef (IDLE..WAIT), WORD_SIZE_DEF=8 and FRAME_WAIT = WORD_SIZE_DEF+2.
REQ-034 Request selection SHALL live in the sub-module uart_rr_arbiter (inputs req and advance; output one-hot winner); the macro affects only this sub-module.

Verification
REQ-035 Single request: req=4'b0001, req_data[7:0]=8'hA5 -> Load_XMT_datareg with Data_Bus=8'hA5 one cycle after req, then Byte_ready, then T_byte, then ack[0] 14 cycles after req was sampled; the transmitter serial line shows 0, then 1010_0101 LSB-first, then 1.
REQ-036 Contention, round-robin: req=4'b1111 held -> grant order 0,1,2,3,0, one idle cycle between frames, each ack 14 cycles after its grant.
REQ-037 Contention with UART_TX_ARB_FIXED_PRIO_EN defined: req=4'b0110 held -> requester 1 is granted repeatedly and requester 2 is never granted while req[1] stays high.
REQ-038 Drop before grant: req[2] pulsed for 1 cycle during requester 0's WAIT -> no grant and no ack to 2.
REQ-039 Reset mid-frame: reset_ driven low in WAIT cycle 5 -> all outputs 0 immediately, no ack; after release, a fresh req=4'b0010 completes a normal frame.
REQ-040 Strobe exclusivity assertion: at most one of the three strobes is high in any cycle, checked over 1000 random req patterns.
